// File: rtl/pio_bank_pkg.sv
// rtl/pio_bank_pkg.sv - register map offsets, parameter limits and byte-lane helpers for pio_bank
package pio_bank_pkg;

  localparam int MAX_NUM_OUT    = 8;
  localparam int MAX_OUT_W      = 32;
  localparam int MAX_IN_W       = 32;
  localparam int MIN_DEB_CYCLES = 2;

  // Output channels always start at word 0; the remaining registers follow them.
  localparam int OUT_BASE = 0;

  function automatic int in_data_ofs(input int num_out);
    return num_out;
  endfunction

  function automatic int edge_ofs(input int num_out);
    return num_out + 1;
  endfunction

  function automatic int mask_ofs(input int num_out);
    return num_out + 2;
  endfunction

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  // Replace only the enabled bits of the old register value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [31:0] m);
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/pio_bank_debounce.sv
// rtl/pio_bank_debounce.sv - input synchroniser with optional shared debounce counter (PIO_BANK_DEBOUNCE_EN)
module pio_bank_debounce
  import pio_bank_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int DEB_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_async,
  output logic [IN_W-1:0] deb
);

  logic [IN_W-1:0] sync1;
  logic [IN_W-1:0] sync2;

  if (DEB_CYCLES < MIN_DEB_CYCLES) begin : g_bad_deb_cycles
    $error("pio_bank_debounce: DEB_CYCLES must be at least 2");
  end

  // Two-flop synchroniser for the asynchronous switch/key inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_async;
      sync2 <= sync1;
    end
  end

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  deb_q;
  logic             changing;

  // sync1 holds the next value of sync2, so a mismatch means the synchronised vector changes this edge.
  assign changing = (sync1 != sync2);

  // One counter shared by all bits: restart on any change, saturate, load the vector once stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      deb_q <= '0;
    end else begin
      if (changing) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (!changing && (cnt == CNT_MAX)) begin
        deb_q <= sync2;
      end
    end
  end

  assign deb = deb_q;
`else
  assign deb = sync2;
`endif

endmodule

// File: rtl/pio_bank.sv
// rtl/pio_bank.sv - Avalon-MM parallel I/O bank: output registers, debounced inputs, edge capture, irq (PIO_BANK_DEBOUNCE_EN)
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int  NUM_OUT    = 2,
  parameter int  OUT_W      = 32,
  parameter int  IN_W       = 16,
  parameter int  DEB_CYCLES = 50000,
  localparam int ADDR_W     = $clog2(NUM_OUT + 3)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic [3:0]               avs_byteenable,
  output logic [31:0]              avs_readdata,
  output logic                     avs_readdatavalid,
  input  logic [IN_W-1:0]          in_port,
  output logic [NUM_OUT*OUT_W-1:0] out_port,
  output logic                     irq
);

  localparam logic [31:0] IN_ADDR   = 32'(in_data_ofs(NUM_OUT));
  localparam logic [31:0] EDGE_ADDR = 32'(edge_ofs(NUM_OUT));
  localparam logic [31:0] MASK_ADDR = 32'(mask_ofs(NUM_OUT));

  if (NUM_OUT < 1 || NUM_OUT > MAX_NUM_OUT) begin : g_bad_num_out
    $error("pio_bank: NUM_OUT out of range");
  end
  if (OUT_W < 1 || OUT_W > MAX_OUT_W) begin : g_bad_out_w
    $error("pio_bank: OUT_W out of range");
  end
  if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_in_w
    $error("pio_bank: IN_W out of range");
  end

  logic [OUT_W-1:0] out_q [NUM_OUT];
  logic [IN_W-1:0]  deb;
  logic [IN_W-1:0]  deb_prev;
  logic [IN_W-1:0]  edge_q;
  logic [IN_W-1:0]  mask_q;
  logic [IN_W-1:0]  w1c;
  logic [31:0]      be_mask;
  logic [31:0]      addr_w;
  logic [31:0]      rd_mux;

  pio_bank_debounce #(
    .IN_W       (IN_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .in_async (in_port),
    .deb      (deb)
  );

  assign addr_w  = 32'(avs_address);
  assign be_mask = lane_mask(avs_byteenable);
  assign w1c     = (avs_write && (addr_w == EDGE_ADDR)) ? IN_W'(avs_writedata & be_mask) : '0;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_port[g*OUT_W +: OUT_W] = out_q[g];
  end

  // Register file writes, rising-edge capture with set-over-clear priority, registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_OUT; n++) begin
        out_q[n] <= '0;
      end
      deb_prev <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
    end else begin
      deb_prev <= deb;
      edge_q   <= (edge_q & ~w1c) | (deb & ~deb_prev);
      irq      <= |(edge_q & mask_q);
      if (avs_write) begin
        for (int n = 0; n < NUM_OUT; n++) begin
          if (addr_w == 32'(OUT_BASE + n)) begin
            out_q[n] <= OUT_W'(lane_merge(32'(out_q[n]), avs_writedata, be_mask));
          end
        end
        if (addr_w == MASK_ADDR) begin
          mask_q <= IN_W'(lane_merge(32'(mask_q), avs_writedata, be_mask));
        end
      end
    end
  end

  // Read mux over the current (pre-write) register state; unmapped words read 0.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_OUT; n++) begin
      if (addr_w == 32'(OUT_BASE + n)) begin
        rd_mux = 32'(out_q[n]);
      end
    end
    if (addr_w == IN_ADDR) begin
      rd_mux = 32'(deb);
    end
    if (addr_w == EDGE_ADDR) begin
      rd_mux = 32'(edge_q);
    end
    if (addr_w == MASK_ADDR) begin
      rd_mux = 32'(mask_q);
    end
  end

  // Fixed one-cycle read response; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule
